// File: rtl/seq_multiplier_param.sv
// Parametrised shift-add multiplier with optional signed mode and early termination
// once the multiplier has no set bits left. One operation at a time, start/ready/done.
module seq_multiplier_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Product,
  output logic               ready,
  output logic               done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [0:0]       state_q,   state_d;
  logic [PW-1:0]    mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplr_q,    mplr_d;
  logic [PW-1:0]    acc_q,     acc_d;
  logic             neg_q,     neg_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [PW-1:0]    product_q, product_d;
  logic             done_q,    done_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;
  logic             last_iter;

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign a_mag = (signed_mode && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign b_mag = (signed_mode && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

  assign addend    = mplr_q[0] ? mcand_q : '0;
  assign sum       = acc_q + addend;
  assign last_iter = (mplr_q[WIDTH-1:1] == '0) || (cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = {{WIDTH{1'b0}}, a_mag};
          mplr_d  = b_mag;
          neg_d   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last_iter) begin
          // Negating a zero sum yields zero, so -0 never appears.
          product_d = neg_q ? (~sum + PW'(1)) : sum;
          state_d   = IDLE;
          done_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign Product = product_q;
  assign ready   = (state_q == IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed-vector bench for seq_multiplier_param at WIDTH=8 plus a WIDTH=16 random
// sweep against a behavioural multiply reference.
module tb_seq_multiplier_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        rdy8, dn8;

  logic        st16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;
  logic        rdy16, dn16;

  seq_multiplier_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(sm8), .A(a8), .B(b8),
    .Product(p8), .ready(rdy8), .done(dn8)
  );

  seq_multiplier_param #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(st16), .signed_mode(sm16), .A(a16), .B(b16),
    .Product(p16), .ready(rdy16), .done(dn16)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one operation and measures k (edges from start edge to done) and ready-low cycles.
  task automatic run_op(input bit w16, input bit sm, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] prod, output int k, output int rl);
    int guard = 0;
    while (!(w16 ? rdy16 : rdy8) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) check("ready_wait_timeout", 32'd0, 32'd1);
    if (w16) begin st16 = 1'b1; sm16 = sm; a16 = a; b16 = b; end
    else     begin st8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; end
    @(posedge clk); #1;
    st8 = 1'b0; st16 = 1'b0;
    rl = (w16 ? rdy16 : rdy8) ? 0 : 1;
    k = 0;
    while (!(w16 ? dn16 : dn8) && k < 100) begin
      @(posedge clk); #1; k++;
      if (!(w16 ? rdy16 : rdy8)) rl++;
    end
    if (k >= 100) check("done_wait_timeout", 32'd0, 32'd1);
    prod = w16 ? p16 : {16'h0, p8};
    if (!w16) begin
      check("ready_with_done", {31'd0, rdy8}, 32'd1);
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, dn8}, 32'd0);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    bit          sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          k;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [31:0] prod;
    int          k, rl, cyc, ndone, first_done;
    int          dq[$];
    string       nm;

    vt[0]  = '{1'b0, 8'd255, 8'd255, 16'hFE01, 8};
    vt[1]  = '{1'b0, 8'd7,   8'd0,   16'd0,    1};
    vt[2]  = '{1'b0, 8'd9,   8'd5,   16'd45,   3};
    vt[3]  = '{1'b1, 8'h80,  8'h80,  16'h4000, 8};
    vt[4]  = '{1'b1, 8'hFD,  8'd5,   16'hFFF1, 3};
    vt[5]  = '{1'b1, 8'd0,   8'hFF,  16'd0,    1};
    vt[6]  = '{1'b0, 8'd0,   8'hFF,  16'd0,    8};
    vt[7]  = '{1'b1, 8'h7F,  8'h80,  16'hC080, 8};
    vt[8]  = '{1'b0, 8'd12,  8'd12,  16'd144,  4};
    vt[9]  = '{1'b1, 8'hFF,  8'hFF,  16'd1,    1};
    vt[10] = '{1'b0, 8'd1,   8'h80,  16'd128,  8};
    vt[11] = '{1'b1, 8'd5,   8'hFD,  16'hFFF1, 2};

    // Reset values while rst is held.
    #12;
    check("rst_product", {16'h0, p8}, 32'd0);
    check("rst_ready",   {31'd0, rdy8}, 32'd1);
    check("rst_done",    {31'd0, dn8}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, vt[i].sm, {8'h0, vt[i].a}, {8'h0, vt[i].b}, prod, k, rl);
      nm = $sformatf("vec%0d_product", i); check(nm, prod, {16'h0, vt[i].p});
      nm = $sformatf("vec%0d_latency", i); check(nm, k, vt[i].k);
      nm = $sformatf("vec%0d_ready_low", i); check(nm, rl, vt[i].k);
    end

    // start pulsed mid-operation must be ignored.
    st8 = 1'b1; sm8 = 1'b0; a8 = 8'd255; b8 = 8'd255;
    @(posedge clk); #1; st8 = 1'b0;
    cyc = 0; ndone = 0; first_done = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 2) begin st8 = 1'b1; a8 = 8'd1; b8 = 8'd1; end
      if (c == 3) st8 = 1'b0;
      @(posedge clk); #1;
      if (dn8) begin ndone++; if (first_done < 0) first_done = c; end
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_latency", first_done, 8);
    check("ignore_product", {16'h0, p8}, 32'hFE01);

    // start held high: back-to-back with one idle cycle (k=3 -> period 4).
    st8 = 1'b1; sm8 = 1'b0; a8 = 8'd9; b8 = 8'd5;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (dn8) begin
        dq.push_back(c);
        check("b2b_product", {16'h0, p8}, 32'd45);
      end
    end
    st8 = 1'b0;
    check("b2b_done_count_ok", {31'd0, dq.size() >= 3}, 32'd1);
    if (dq.size() >= 3) begin
      check("b2b_period1", dq[1] - dq[0], 4);
      check("b2b_period2", dq[2] - dq[1], 4);
    end
    cyc = 0;
    while (!(rdy8 && !dn8) && cyc < 20) begin @(posedge clk); #1; cyc++; end

    // Asynchronous reset mid-CALC.
    st8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd200;
    @(posedge clk); #1; st8 = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_product", {16'h0, p8}, 32'd0);
    check("arst_ready",   {31'd0, rdy8}, 32'd1);
    check("arst_done",    {31'd0, dn8}, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 1'b0, 16'd12, 16'd12, prod, k, rl);
    check("post_rst_product", prod, 32'd144);
    check("post_rst_latency", k, 4);

    // WIDTH=16 random sweep.
    for (int i = 0; i < 1000; i++) begin
      bit          sm;
      logic [15:0] ra, rb, bm;
      longint      sa, sb, pr;
      int          ek;
      sm = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 1) rb = rb >> $urandom_range(0, 15);
      if (i == 2) begin ra = 16'h8000; rb = 16'h8000; end
      sa = sm ? longint'($signed(ra)) : longint'(ra);
      sb = sm ? longint'($signed(rb)) : longint'(rb);
      pr = sa * sb;
      bm = (sm && rb[15]) ? 16'(-sb) : rb;
      ek = 1;
      for (int j = 0; j < 16; j++) if (bm[j]) ek = j + 1;
      run_op(1'b1, sm, ra, rb, prod, k, rl);
      nm = $sformatf("w16_%0d_product", i); check(nm, prod, pr[31:0]);
      nm = $sformatf("w16_%0d_latency", i); check(nm, k, ek);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_param.md
# seq_multiplier_param

Parametrised sequential shift-add multiplier that succeeds the fixed 8-bit unsigned multiplier in the arithmetic unit. It adds a configurable operand width, a per-operation signed/unsigned mode, early termination on the multiplier's remaining zero bits, and an explicit start/ready/done handshake. It sits beside the ALU as a multi-cycle functional unit. A controller issues one operation at a time and reads `Product` on `done`.

## Interface
- `WIDTH`, default 8: operand width in bits; legal values are ≥ 2. Product width is 2*WIDTH.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a new operation; sampled only while `ready`=1.
- `signed_mode` input 1: 1 treats `A` and `B` as two's complement; 0 treats them as unsigned. Sampled with `start`.
- `A` input WIDTH: multiplicand, sampled with `start`.
- `B` input WIDTH: multiplier, sampled with `start`.
- `Product` output 2*WIDTH: registered result. Holds its value until the next completion.
- `ready` output 1: 1 when idle and able to accept `start`.
- `done` output 1: one-cycle pulse in the first cycle in which a new `Product` is valid.

## Operation
- States:
  - IDLE: `ready`=1.
  - CALC: `ready`=0.
- Reset (asynchronous, takes effect immediately, overrides everything including a mid-operation CALC):
  - state=IDLE, `Product`=0, `done`=0, `ready`=1.
  - Internal accumulator, operand registers, sign flag and counter are cleared.
- IDLE with `start`=1, at the clock edge:
  - Capture magnitudes: `mcand`=|A| zero-extended to 2*WIDTH, `mplr`=|B|. Absolute value is taken only when `signed_mode`=1 and the operand MSB is 1; otherwise the raw value is used.
  - `neg` = `signed_mode` & (A[WIDTH-1] ^ B[WIDTH-1]).
  - acc=0, counter=0, state goes to CALC.
  - `done` is 0 in the next cycle.
- IDLE with `start`=0: nothing changes, and `done` returns to 0.
- CALC, each cycle (iteration i = counter):
  - sum = acc + (`mplr`[0] ? `mcand` : 0), computed modulo 2^(2*WIDTH).
  - `mcand` <<= 1, `mplr` >>= 1, counter += 1, acc <= sum.
  - The iteration is last when (`mplr` >> 1) == 0 or counter == WIDTH-1.
  - On the last iteration:
    - `Product` <= `neg` ? (two's-complement negation of sum) : sum.
    - state <= IDLE, `done` <= 1.
- `start` asserted during CALC is ignored. It is not queued. A requester must hold or re-assert `start` once `ready`=1.
- Arithmetic:
  - The magnitude of the most negative operand, 2^(WIDTH-1), fits in WIDTH unsigned bits.
  - Every signed and unsigned result fits exactly in 2*WIDTH bits, so there is no overflow.
  - A zero result is never negated to a nonzero value (-0 = 0).
- Counter width is $clog2(WIDTH)+1 bits.

## Timing
- Start-to-result latency is k clock edges after the `start` edge, where k = max(1, index of highest set bit of |B| + 1).
  - For B=0, k=1.
  - Worst case is k=WIDTH.
- `done`=1 and `ready`=1 in the cycle following the k-th CALC edge.
- A new `start` may be asserted in that same cycle (back-to-back operation).
  - It is accepted at the next edge.
  - That edge clears `done` to 0; if the new operation completes at k=1, `done` pulses again one cycle later.
- Throughput is one operation per (k+1) cycles when `start` is held high.
- `Product` changes only at completion edges and on reset.

## Test plan
- Unsigned, WIDTH=8: A=255, B=255, `signed_mode`=0 -> `Product`=65025 (0xFE01); `done` one cycle, 8 edges after start; `ready` low for exactly 8 cycles.
- Early termination: A=7, B=0 -> `Product`=0, k=1. Then A=9, B=5 -> `Product`=45, k=3.
- Signed, WIDTH=8:
  - A=-128 (0x80), B=-128 -> `Product`=16384 (0x4000), k=8.
  - A=-3 (0xFD), B=5 -> `Product`=0xFFF1 (-15), k=3.
  - A=0, B=-1 -> `Product`=0.
- Handshake:
  - `start` pulsed again 2 cycles into a k=8 operation -> ignored; only one `done`; `Product` equals the first operation's result.
  - `start` held high continuously -> back-to-back results with exactly one idle cycle between operations.
- Reset: assert `rst` asynchronously (mid-cycle) during CALC of A=200, B=200 -> immediately `Product`=0, `ready`=1, `done`=0. After release, the next operation 12*12 returns 144 with correct latency k=4.
- WIDTH=16: 1000 random signed and unsigned operand pairs against a reference model -> all products match; latency equals k for each pair.
